// File: rtl/handshaking_xbar_nxm_if.sv
`default_nettype none
// ============================================================================
//  Module      : handshaking_xbar_nxm_if
//  Description : Bundle of master-side and slave-side valid/ready signals of
//                the N x M handshaking crossbar.
//                master modport : environment view (drives masters' beats
//                                 and slaves' ready).
//                slave modport  : crossbar view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface handshaking_xbar_nxm_if #(
    parameter int DATA_W = 8,
    parameter int N_M    = 2,
    parameter int N_S    = 2,
    parameter int DEST_W = 1
) ();
    logic [N_M*DATA_W-1:0] data_out_m;
    logic [N_M*DEST_W-1:0] dest_out_m;
    logic [N_M-1:0]        valid_out_m;
    logic [N_M-1:0]        ready_in_m;
    logic [N_M-1:0]        err_m;
    logic [N_S*DATA_W-1:0] data_in_s;
    logic [N_S-1:0]        valid_in_s;
    logic [N_S-1:0]        ready_out_s;

    modport master (
        output data_out_m, dest_out_m, valid_out_m, ready_out_s,
        input  ready_in_m, err_m, data_in_s, valid_in_s
    );

    modport slave (
        input  data_out_m, dest_out_m, valid_out_m, ready_out_s,
        output ready_in_m, err_m, data_in_s, valid_in_s
    );
endinterface
`default_nettype wire

// File: rtl/handshaking_xbar_nxm.sv
`default_nettype none
// ============================================================================
//  Module      : handshaking_xbar_nxm
//  Description : N-master x M-slave valid/ready crossbar. Each slave port has
//                a round-robin arbiter that locks onto its winner while the
//                slave back-pressures. Beats with an out-of-range destination
//                are accepted, dropped and flagged on err_m.
//  Options     : XBAR_OUT_REG_EN - registers each slave port through a
//                2-entry skid buffer (1-cycle latency, full throughput).
//  Revision    : 1.0 - initial release
// ============================================================================
module handshaking_xbar_nxm #(
    parameter int DATA_W = 8,
    parameter int N_M    = 2,
    parameter int N_S    = 2,
    parameter int DEST_W = 1
) (
    input wire                    clk,
    input wire                    rst,
    handshaking_xbar_nxm_if.slave bus
);
    localparam int c_IDX_W = $clog2(N_M);

    logic [DATA_W-1:0] w_m_data [N_M];
    logic [DEST_W-1:0] w_m_dest [N_M];
    logic [N_M-1:0]    w_m_oor;
    logic [N_M-1:0]    w_ack_s  [N_S];
    logic [N_M-1:0]    w_ack_any;

    // Unpack master buses; flag beats whose destination has no slave
    for (genvar i = 0; i < N_M; i++) begin : g_m
        assign w_m_data[i] = bus.data_out_m[i*DATA_W +: DATA_W];
        assign w_m_dest[i] = bus.dest_out_m[i*DEST_W +: DEST_W];
        assign w_m_oor[i]  = bus.valid_out_m[i] && (int'(w_m_dest[i]) >= N_S);
    end

    for (genvar j = 0; j < N_S; j++) begin : g_s
        logic [N_M-1:0]     w_req;
        logic               w_found;
        logic [c_IDX_W-1:0] w_win;
        logic               w_gnt_vld;
        logic [c_IDX_W-1:0] w_gnt_idx;
        logic [c_IDX_W-1:0] w_next;
        logic               w_route_vld;
        logic [DATA_W-1:0]  w_route_data;
        logic               w_arb_rdy;
        logic               w_xfer;
        logic [c_IDX_W-1:0] r_rr_ptr;
        logic               r_lock;
        logic [c_IDX_W-1:0] r_gnt;

        for (genvar i = 0; i < N_M; i++) begin : g_req
            assign w_req[i] = bus.valid_out_m[i] && (w_m_dest[i] == DEST_W'(j));
        end

        // Round-robin scan starting at the priority pointer
        always_comb begin
            w_found = 1'b0;
            w_win   = '0;
            for (int k = 0; k < N_M; k++) begin
                if (!w_found && w_req[(int'(r_rr_ptr) + k) % N_M]) begin
                    w_found = 1'b1;
                    w_win   = c_IDX_W'((int'(r_rr_ptr) + k) % N_M);
                end
            end
        end

        // A locked slave only listens to its held master; reset blanks all routes
        assign w_gnt_vld    = r_lock || w_found;
        assign w_gnt_idx    = r_lock ? r_gnt : w_win;
        assign w_next       = c_IDX_W'((int'(w_gnt_idx) + 1) % N_M);
        assign w_route_vld  = !rst && w_gnt_vld && bus.valid_out_m[w_gnt_idx];
        assign w_route_data = w_route_vld ? w_m_data[w_gnt_idx] : '0;
        assign w_xfer       = w_route_vld && w_arb_rdy;
        assign w_ack_s[j]   = w_xfer ? ({{(N_M-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

        // Arbiter state: lock on a stalled grant, advance pointer past each winner
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rr_ptr <= '0;
                r_lock   <= 1'b0;
                r_gnt    <= '0;
            end else if (r_lock) begin
                if (w_xfer) begin
                    r_lock   <= 1'b0;
                    r_rr_ptr <= w_next;
                end
            end else if (w_found) begin
                if (w_arb_rdy) begin
                    r_rr_ptr <= w_next;
                end else begin
                    r_lock <= 1'b1;
                    r_gnt  <= w_win;
                end
            end
        end

`ifdef XBAR_OUT_REG_EN
        logic [DATA_W-1:0] r_buf [2];
        logic [1:0]        r_cnt;
        logic              r_wr;
        logic              r_rd;
        logic              w_push;
        logic              w_pop;

        assign w_arb_rdy = (r_cnt != 2'd2);
        assign w_push    = w_xfer;
        assign w_pop     = (r_cnt != 2'd0) && bus.ready_out_s[j];

        // Two-entry skid buffer decouples slave backpressure from the arbiter
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= 2'd0;
                r_wr  <= 1'b0;
                r_rd  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_buf[r_wr] <= w_route_data;
                    r_wr        <= ~r_wr;
                end
                if (w_pop) begin
                    r_rd <= ~r_rd;
                end
                r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
            end
        end

        assign bus.valid_in_s[j]                 = (r_cnt != 2'd0);
        assign bus.data_in_s[j*DATA_W +: DATA_W] = (r_cnt != 2'd0) ? r_buf[r_rd] : '0;
`else
        assign w_arb_rdy                         = bus.ready_out_s[j];
        assign bus.valid_in_s[j]                 = w_route_vld;
        assign bus.data_in_s[j*DATA_W +: DATA_W] = w_route_data;
`endif
    end

    // Merge per-slave acknowledges; a master holds at most one grant
    always_comb begin
        w_ack_any = '0;
        for (int j = 0; j < N_S; j++) begin
            w_ack_any = w_ack_any | w_ack_s[j];
        end
    end

    assign bus.ready_in_m = rst ? '0 : (w_ack_any | w_m_oor);
    assign bus.err_m      = rst ? '0 : w_m_oor;

endmodule
`default_nettype wire
